// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 board engine.
// Direction encoding follows the button bit order of the input logic.
package game_2048_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_UP    = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LINE  = 3'd1,
      SPAWN = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int TILE_2 = 2;
   localparam int TILE_4 = 4;

   // Flat cell index of (row, col) on an n-wide board, row 0 at the top.
   function automatic int cellIndex(input int r, input int c, input int n);
      return r * n + c;
   endfunction

endpackage

// File: rtl/line_slide_merge.sv
// Combinational slide-and-merge of a single line, cell 0 being the leading edge.
// Produces the new line, the sum of merged tile values, and whether anything changed.
module line_slide_merge
   import game_2048_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 12,
   parameter int SW = W + $clog2(N)
) (
   input  logic [N*W-1:0] line_i,
   output logic [N*W-1:0] line_o,
   output logic [SW-1:0]  score_o,
   output logic           changed_o
);

   localparam logic [W-1:0] MAX_TILE = {1'b1, {(W-1){1'b0}}};

   // One spare zero slot lets the merge look one cell past the end safely.
   logic [W-1:0] comp [N+1];

   always_comb begin
      int cnt;
      cnt = 0;
      for (int i = 0; i <= N; i++) begin
         comp[i] = '0;
      end
      for (int i = 0; i < N; i++) begin
         if (line_i[i*W +: W] != '0) begin
            comp[cnt] = line_i[i*W +: W];
            cnt++;
         end
      end
   end

   // A merged pair consumes both tiles, so the next tile can never re-merge.
   always_comb begin
      int           oc;
      logic         skip;
      logic [W-1:0] merged;
      line_o  = '0;
      score_o = '0;
      oc      = 0;
      skip    = 1'b0;
      merged  = '0;
      for (int i = 0; i < N; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[i] != '0) begin
            if (comp[i+1] == comp[i] && comp[i] != MAX_TILE) begin
               merged            = comp[i] << 1;
               line_o[oc*W +: W] = merged;
               score_o           = score_o + SW'(merged);
               skip              = 1'b1;
            end else begin
               line_o[oc*W +: W] = comp[i];
            end
            oc++;
         end
      end
   end

   assign changed_o = (line_o != line_i);

endmodule

// File: rtl/board_move_engine.sv
// Sequential 2048 move engine: slides one line per cycle, spawns a tile if the
// board changed, then evaluates win/loss. board_out_o feeds the VGA renderer.
module board_move_engine
   import game_2048_pkg::*;
#(
   parameter int N         = 4,
   parameter int W         = 12,
   parameter int WIN_VALUE = 2048,
   parameter int SCORE_W   = 20
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [1:0]             dir_i,
   input  logic                   load_i,
   input  logic [N*N*W-1:0]       board_in_i,
   input  logic [$clog2(N*N)-1:0] rand_pos_i,
   input  logic                   rand_val_i,
   output logic [N*N*W-1:0]       board_out_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   moved_o,
   output logic [SCORE_W-1:0]     score_o,
   output logic                   won_o,
   output logic                   lost_o
);

   localparam int CELLS = N * N;
   localparam int PW    = $clog2(CELLS);
   localparam int KW    = $clog2(N);
   localparam int LSW   = W + $clog2(N);
   localparam logic [W:0] WIN_TILE = (W+1)'(WIN_VALUE);

   state_t               state_q, state_d;
   dir_t                 dir_q, dir_d;
   logic [KW-1:0]        lineIdx_q, lineIdx_d;
   logic [CELLS*W-1:0]   board_q, board_d;
   logic                 moved_q, moved_d;
   logic                 done_q, done_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 won_q, won_d;
   logic                 lost_q, lost_d;

   logic [N*W-1:0]       lineIn, lineOut;
   logic [LSW-1:0]       lineScore;
   logic                 lineChanged;
   logic                 spawnFound;
   logic [PW-1:0]        spawnIdx;
   logic                 anyWin, anyEmpty, anyPair;
   logic [SCORE_W:0]     scoreSum;

   // Position j along line k, j = 0 being the cell at the leading edge.
   function automatic int lineCell(input dir_t d, input int k, input int j);
      case (d)
         DIR_LEFT:  return cellIndex(k, j, N);
         DIR_RIGHT: return cellIndex(k, N-1-j, N);
         DIR_UP:    return cellIndex(j, k, N);
         default:   return cellIndex(N-1-j, k, N);
      endcase
   endfunction

   always_comb begin
      lineIn = '0;
      for (int j = 0; j < N; j++) begin
         lineIn[j*W +: W] = board_q[lineCell(dir_q, int'(lineIdx_q), j)*W +: W];
      end
   end

   line_slide_merge #(
      .N  (N),
      .W  (W),
      .SW (LSW)
   ) u_line (
      .line_i    (lineIn),
      .line_o    (lineOut),
      .score_o   (lineScore),
      .changed_o (lineChanged)
   );

   // First empty cell at or after rand_pos_i, wrapping past the last cell.
   always_comb begin
      int idx;
      spawnFound = 1'b0;
      spawnIdx   = '0;
      idx        = 0;
      for (int off = 0; off < CELLS; off++) begin
         idx = (int'(rand_pos_i) + off) % CELLS;
         if (!spawnFound && board_q[idx*W +: W] == '0) begin
            spawnFound = 1'b1;
            spawnIdx   = PW'(idx);
         end
      end
   end

   // Neighbour indices are clamped at the edges so every select stays in range.
   always_comb begin
      logic [W-1:0] cur;
      int           rightIdx, downIdx;
      anyWin   = 1'b0;
      anyEmpty = 1'b0;
      anyPair  = 1'b0;
      cur      = '0;
      rightIdx = 0;
      downIdx  = 0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            cur      = board_q[cellIndex(r, c, N)*W +: W];
            rightIdx = (c < N-1) ? cellIndex(r, c+1, N) : cellIndex(r, c, N);
            downIdx  = (r < N-1) ? cellIndex(r+1, c, N) : cellIndex(r, c, N);
            if ({1'b0, cur} >= WIN_TILE) anyWin = 1'b1;
            if (cur == '0) anyEmpty = 1'b1;
            if (c < N-1 && cur == board_q[rightIdx*W +: W]) anyPair = 1'b1;
            if (r < N-1 && cur == board_q[downIdx*W +: W]) anyPair = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      lineIdx_d = lineIdx_q;
      board_d   = board_q;
      moved_d   = moved_q;
      done_d    = 1'b0;
      score_d   = score_q;
      won_d     = won_q;
      lost_d    = lost_q;
      scoreSum  = '0;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               board_d = board_in_i;
               score_d = '0;
               won_d   = 1'b0;
               lost_d  = 1'b0;
            end else if (start_i && !lost_q) begin
               dir_d     = dir_t'(dir_i);
               moved_d   = 1'b0;
               lineIdx_d = '0;
               state_d   = LINE;
            end
         end
         LINE: begin
            for (int j = 0; j < N; j++) begin
               board_d[lineCell(dir_q, int'(lineIdx_q), j)*W +: W] = lineOut[j*W +: W];
            end
            scoreSum = {1'b0, score_q} + (SCORE_W+1)'(lineScore);
            score_d  = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
            moved_d  = moved_q | lineChanged;
            if (lineIdx_q == KW'(N-1)) begin
               state_d = SPAWN;
            end else begin
               lineIdx_d = lineIdx_q + 1'b1;
            end
         end
         SPAWN: begin
            if (moved_q && spawnFound) begin
               board_d[spawnIdx*W +: W] = rand_val_i ? W'(TILE_4) : W'(TILE_2);
            end
            state_d = CHECK;
         end
         CHECK: begin
            won_d   = won_q | anyWin;
            lost_d  = !anyEmpty && !anyPair;
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         dir_q     <= DIR_RIGHT;
         lineIdx_q <= '0;
         board_q   <= '0;
         moved_q   <= 1'b0;
         done_q    <= 1'b0;
         score_q   <= '0;
         won_q     <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         lineIdx_q <= lineIdx_d;
         board_q   <= board_d;
         moved_q   <= moved_d;
         done_q    <= done_d;
         score_q   <= score_d;
         won_q     <= won_d;
         lost_q    <= lost_d;
      end
   end

   // done is registered out of DONE, so busy has already dropped when it pulses.
   assign board_out_o = board_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign moved_o     = moved_q;
   assign score_o     = score_q;
   assign won_o       = won_q;
   assign lost_o      = lost_q;

endmodule

// File: tb/tb_board_move_engine.sv
// Scoreboard bench for board_move_engine: each move pushes its expected
// result, and a monitor pops and compares whenever done pulses.
module tb_board_move_engine;
   import game_2048_pkg::*;

   localparam int N       = 4;
   localparam int W       = 12;
   localparam int SCORE_W = 20;
   localparam int BW      = N * N * W;
   localparam int PW      = $clog2(N * N);
   localparam int LAT     = N + 3;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [1:0]          dir = 2'd0;
   logic                load = 1'b0;
   logic [BW-1:0]       boardIn = '0;
   logic [PW-1:0]       randPos = '0;
   logic                randVal = 1'b0;
   logic [BW-1:0]       boardOut;
   logic                busy, done, moved, won, lost;
   logic [SCORE_W-1:0]  score;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string              name;
      logic [BW-1:0]      board;
      logic [SCORE_W-1:0] score;
      logic               moved;
      logic               won;
      logic               lost;
   } exp_t;

   exp_t sbQ[$];

   always #5 clock = ~clock;

   board_move_engine #(
      .N         (N),
      .W         (W),
      .WIN_VALUE (2048),
      .SCORE_W   (SCORE_W)
   ) dut (
      .clk_i       (clock),
      .rst_i       (reset),
      .start_i     (start),
      .dir_i       (dir),
      .load_i      (load),
      .board_in_i  (boardIn),
      .rand_pos_i  (randPos),
      .rand_val_i  (randVal),
      .board_out_o (boardOut),
      .busy_o      (busy),
      .done_o      (done),
      .moved_o     (moved),
      .score_o     (score),
      .won_o       (won),
      .lost_o      (lost)
   );

   function automatic logic [BW-1:0] putRow(input logic [BW-1:0] b, input int r,
                                            input int v0, input int v1, input int v2, input int v3);
      logic [BW-1:0] t;
      t = b;
      t[(r*N+0)*W +: W] = W'(v0);
      t[(r*N+1)*W +: W] = W'(v1);
      t[(r*N+2)*W +: W] = W'(v2);
      t[(r*N+3)*W +: W] = W'(v3);
      return t;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest pending expectation.
   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (done === 1'b1) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, expected no pending move");
         end else begin
            e = sbQ.pop_front();
            checks++;
            if (boardOut !== e.board) begin
               errors++;
               $display("[TB] FAIL %s board: got %h expected %h", e.name, boardOut, e.board);
            end
            checks++;
            if (score !== e.score) begin
               errors++;
               $display("[TB] FAIL %s score: got %0d expected %0d", e.name, score, e.score);
            end
            checks++;
            if (moved !== e.moved) begin
               errors++;
               $display("[TB] FAIL %s moved: got %b expected %b", e.name, moved, e.moved);
            end
            checks++;
            if (won !== e.won) begin
               errors++;
               $display("[TB] FAIL %s won: got %b expected %b", e.name, won, e.won);
            end
            checks++;
            if (lost !== e.lost) begin
               errors++;
               $display("[TB] FAIL %s lost: got %b expected %b", e.name, lost, e.lost);
            end
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL %s busy_at_done: got %b expected 0", e.name, busy);
            end
         end
      end
   end

   task automatic loadBoard(input logic [BW-1:0] b);
      @(negedge clock);
      start   = 1'b0;
      boardIn = b;
      load    = 1'b1;
      @(negedge clock);
      load    = 1'b0;
   endtask

   // Issues one move, queues its expected result and checks done latency.
   task automatic runMove(input string name, input logic [1:0] d, input logic [PW-1:0] rp,
                          input logic rv, input logic [BW-1:0] expBoard,
                          input logic [SCORE_W-1:0] expScore, input logic expMoved,
                          input logic expWon, input logic expLost);
      exp_t e;
      int   cycles;
      bit   seen;
      @(negedge clock);
      dir     = d;
      randPos = rp;
      randVal = rv;
      start   = 1'b1;
      e.name  = name;
      e.board = expBoard;
      e.score = expScore;
      e.moved = expMoved;
      e.won   = expWon;
      e.lost  = expLost;
      sbQ.push_back(e);
      @(posedge clock);
      #1;
      start  = 1'b0;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 4 * LAT) begin
         @(posedge clock);
         cycles++;
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || cycles != LAT) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d cycles (done seen=%0b) expected %0d", name, cycles, seen, LAT);
      end
      if (!seen && sbQ.size() > 0) void'(sbQ.pop_back());
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (boardOut !== '0) begin
         errors++;
         $display("[TB] FAIL reset_board: got %h expected 0", boardOut);
      end
      checks++;
      if (score !== '0) begin
         errors++;
         $display("[TB] FAIL reset_score: got %0d expected 0", score);
      end
      checks++;
      if ({busy, done, moved, won, lost} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, moved, won, lost});
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_merge_once_left();
      loadBoard(putRow('0, 0, 2, 2, 4, 0));
      runMove("merge_left", DIR_LEFT, PW'(0), 1'b0, putRow('0, 0, 4, 4, 2, 0), 4, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_merge_right();
      loadBoard(putRow('0, 0, 2, 2, 2, 2));
      runMove("merge_right", DIR_RIGHT, PW'(0), 1'b0, putRow('0, 0, 2, 0, 4, 4), 8, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_no_move();
      logic [BW-1:0] b;
      b = putRow(putRow('0, 0, 2, 4, 0, 0), 1, 8, 2, 0, 0);
      // load and start together: load takes effect, start is dropped
      @(negedge clock);
      boardIn = b;
      load    = 1'b1;
      start   = 1'b1;
      dir     = DIR_LEFT;
      @(negedge clock);
      load  = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || boardOut !== b) begin
         errors++;
         $display("[TB] FAIL load_beats_start: got busy=%b board=%h expected busy=0 board=%h", busy, boardOut, b);
      end
      runMove("no_move", DIR_LEFT, PW'(0), 1'b0, b, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_spawn_wrap();
      logic [BW-1:0] full3;
      full3 = putRow(putRow(putRow('0, 0, 2, 4, 8, 16), 1, 2, 4, 8, 16), 2, 2, 4, 8, 16);
      loadBoard(putRow(full3, 3, 0, 2, 4, 8));
      runMove("spawn_end", DIR_LEFT, PW'(14), 1'b1, putRow(full3, 3, 2, 4, 8, 4), 0, 1'b1, 1'b0, 1'b0);
      full3 = putRow(putRow(putRow('0, 1, 2, 4, 8, 16), 2, 2, 4, 8, 16), 3, 2, 4, 8, 16);
      loadBoard(putRow(full3, 0, 2, 4, 8, 0));
      runMove("spawn_wrap", DIR_RIGHT, PW'(14), 1'b1, putRow(full3, 0, 4, 2, 4, 8), 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_lost();
      logic [BW-1:0] rest, finalB;
      bit            activity;
      rest   = putRow(putRow(putRow('0, 1, 4, 2, 4, 2), 2, 2, 4, 2, 4), 3, 4, 2, 4, 2);
      finalB = putRow(rest, 0, 2, 4, 2, 4);
      loadBoard(putRow(rest, 0, 4, 2, 4, 0));
      runMove("checkerboard", DIR_RIGHT, PW'(0), 1'b0, finalB, 0, 1'b1, 1'b0, 1'b1);
      // start held high after a loss must be ignored entirely
      @(negedge clock);
      dir      = DIR_LEFT;
      start    = 1'b1;
      activity = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         if (busy !== 1'b0 || done !== 1'b0) activity = 1'b1;
      end
      start = 1'b0;
      checks++;
      if (activity) begin
         errors++;
         $display("[TB] FAIL start_after_lost: got busy/done activity=1 expected 0");
      end
      checks++;
      if (boardOut !== finalB) begin
         errors++;
         $display("[TB] FAIL board_after_lost: got %h expected %h", boardOut, finalB);
      end
      loadBoard(putRow('0, 0, 2, 0, 0, 0));
      checks++;
      if (lost !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_clears_lost: got %b expected 0", lost);
      end
   endtask

   task automatic test_win_and_reset();
      loadBoard(putRow('0, 0, 1024, 1024, 0, 0));
      runMove("win", DIR_LEFT, PW'(0), 1'b0, putRow('0, 0, 2048, 2, 0, 0), 2048, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      dir   = DIR_LEFT;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_mid_move: got %b expected 1", busy);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (boardOut !== '0) begin
         errors++;
         $display("[TB] FAIL abort_board: got %h expected 0", boardOut);
      end
      checks++;
      if ({busy, done, won} !== 3'b0 || score !== '0) begin
         errors++;
         $display("[TB] FAIL abort_state: got busy/done/won=%b score=%0d expected 000 score=0", {busy, done, won}, score);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_merge_once_left();
      test_merge_right();
      test_no_move();
      test_spawn_wrap();
      test_lost();
      test_win_and_reset();
      repeat (3) @(posedge clock);
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
